// File: rtl/system_pkg.sv
// Shared system-level definitions for the loader / RAM / dump-reader slice.
// Holds the default RAM geometry, the dump-reader FSM encoding and the
// top-level system_state encoding that sequences memory ownership.
package system_pkg;

  localparam int unsigned SYS_ADDR_WIDTH = 16;
  localparam int unsigned SYS_DATA_WIDTH = 16;

  // Dump-reader FSM encoding (values are fixed so that state dumps from
  // older captures remain readable).
  typedef enum logic [2:0] {
    DUMP_IDLE  = 3'd0,
    DUMP_ISSUE = 3'd1,
    DUMP_WAIT  = 3'd2,
    DUMP_HOLD  = 3'd3,
    DUMP_DONE  = 3'd4
  } dump_state_e;

  // System sequencing: the dump reader owns the RAM port only in DUMPING,
  // which follows EXECUTING.
  typedef enum logic [2:0] {
    SYS_RESET     = 3'd0,
    SYS_LOADING   = 3'd1,
    SYS_EXECUTING = 3'd2,
    SYS_DUMPING   = 3'd3,
    SYS_HALTED    = 3'd4
  } system_state_e;

endpackage

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: walks a contiguous RAM window after execution and streams
// each word out on a valid/ready interface, tagged with its address.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   start                one-cycle pulse, accepted only in IDLE or DONE
//   base_addr, length    dump window, sampled on the accepted start
//   mem_addr, mem_read   RAM read request (mem_read is one cycle per word)
//   mem_read_data        RAM data, valid MEM_LATENCY cycles after mem_read
//   out_valid/out_ready  output handshake
//   out_data, out_addr   dumped word and its address
//   busy                 high from accepted start until the last handshake
//   done                 one-cycle completion pulse
module mem_dump_reader
  import system_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = SYS_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = SYS_DATA_WIDTH,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned LAT_W = 2;

  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
    $error("mem_dump_reader: MEM_LATENCY must be in 1..4");
  end

  dump_state_e           state_q,     state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q,  cur_addr_d;
  logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
  logic [LAT_W-1:0]      lat_cnt_q,   lat_cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic                  mem_read_q,  mem_read_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= DUMP_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      lat_cnt_q   <= '0;
      mem_addr_q  <= '0;
      mem_read_q  <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      busy_q      <= '0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      lat_cnt_q   <= lat_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_read_q  <= mem_read_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // All outputs are registered; mem_read/mem_addr are loaded on the edge that
  // enters ISSUE so the strobe is high for exactly the ISSUE cycle.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    lat_cnt_d   = lat_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_read_d  = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      DUMP_IDLE, DUMP_DONE: begin
        if (start) begin
          if (length != '0) begin
            cur_addr_d  = base_addr;
            remaining_d = length;
            busy_d      = 1'b1;
            mem_addr_d  = base_addr;
            mem_read_d  = 1'b1;
            state_d     = DUMP_ISSUE;
          end else begin
            done_d  = 1'b1;
            state_d = DUMP_DONE;
          end
        end
      end

      DUMP_ISSUE: begin
        lat_cnt_d = LAT_W'(MEM_LATENCY - 1);
        state_d   = DUMP_WAIT;
      end

      DUMP_WAIT: begin
        if (lat_cnt_q == '0) begin
          out_data_d  = mem_read_data;
          out_addr_d  = cur_addr_q;
          out_valid_d = 1'b1;
          state_d     = DUMP_HOLD;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end

      DUMP_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          remaining_d = remaining_q - ADDR_WIDTH'(1);
          if (remaining_q == ADDR_WIDTH'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DUMP_DONE;
          end else begin
            // Address wraps naturally at the register width.
            cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
            mem_addr_d = cur_addr_q + ADDR_WIDTH'(1);
            mem_read_d = 1'b1;
            state_d    = DUMP_ISSUE;
          end
        end
      end

      default: begin
        state_d = DUMP_IDLE;
      end
    endcase
  end

  assign mem_addr  = mem_addr_q;
  assign mem_read  = mem_read_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: two instances (MEM_LATENCY 1 and 3),
// each with a behavioural RAM whose read data is valid for a single cycle.
module tb_mem_dump_reader;

  localparam int unsigned LAT0 = 1;
  localparam int unsigned LAT1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start_i [2];
  logic [15:0] base_i  [2];
  logic [15:0] len_i   [2];
  logic        ready_i [2];

  logic [15:0] rdata0, rdata1, maddr0, maddr1, odata0, odata1, oaddr0, oaddr1;
  logic        mrd0, mrd1, ov0, ov1, busy0, busy1, done0, done1;

  logic [15:0] maddr [2];
  logic [15:0] odata [2];
  logic [15:0] oaddr [2];
  logic        mrd   [2];
  logic        ov    [2];
  logic        bsy   [2];
  logic        dn    [2];

  always_comb begin
    maddr[0] = maddr0; maddr[1] = maddr1;
    odata[0] = odata0; odata[1] = odata1;
    oaddr[0] = oaddr0; oaddr[1] = oaddr1;
    mrd[0]   = mrd0;   mrd[1]   = mrd1;
    ov[0]    = ov0;    ov[1]    = ov1;
    bsy[0]   = busy0;  bsy[1]   = busy1;
    dn[0]    = done0;  dn[1]    = done1;
  end

  mem_dump_reader #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_LATENCY(LAT0)) u_dut0 (
    .clock(clk), .reset(rst), .start(start_i[0]), .base_addr(base_i[0]),
    .length(len_i[0]), .mem_addr(maddr0), .mem_read(mrd0), .mem_read_data(rdata0),
    .out_valid(ov0), .out_ready(ready_i[0]), .out_data(odata0), .out_addr(oaddr0),
    .busy(busy0), .done(done0)
  );

  mem_dump_reader #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_LATENCY(LAT1)) u_dut1 (
    .clock(clk), .reset(rst), .start(start_i[1]), .base_addr(base_i[1]),
    .length(len_i[1]), .mem_addr(maddr1), .mem_read(mrd1), .mem_read_data(rdata1),
    .out_valid(ov1), .out_ready(ready_i[1]), .out_data(odata1), .out_addr(oaddr1),
    .busy(busy1), .done(done1)
  );

  // RAM contents: 0x10..0x13 preloaded with 0xA000..0xA003, elsewhere addr^0x5A5A.
  function automatic logic [15:0] ram_word(input logic [15:0] a);
    if (a >= 16'h0010 && a <= 16'h0013) return 16'hA000 + (a - 16'h0010);
    return a ^ 16'h5A5A;
  endfunction

  function automatic int unsigned lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  // Read data is valid exactly MEM_LATENCY cycles after mem_read, garbage otherwise.
  logic [15:0] pipe0;
  logic [15:0] pipe1 [3];
  always @(posedge clk) begin
    pipe0    <= mrd0 ? ram_word(maddr0) : 16'hDEAD;
    pipe1[0] <= mrd1 ? ram_word(maddr1) : 16'hDEAD;
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign rdata0 = pipe0;
  assign rdata1 = pipe1[2];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Monitor state, updated once per cycle at the falling edge.
  int unsigned cyc = 0;
  int unsigned mr_n   [2] = '{0, 0};
  int unsigned mr_cyc [2] = '{0, 0};
  int unsigned hs_n   [2] = '{0, 0};
  int unsigned done_n [2] = '{0, 0};
  int unsigned done_cyc [2] = '{0, 0};
  logic [15:0] hs_a [2][64];
  logic [15:0] hs_d [2][64];
  int unsigned hs_c [2][64];
  logic        ov_p [2] = '{1'b0, 1'b0};
  logic        hs_p [2] = '{1'b0, 1'b0};
  logic        bsy_p [2] = '{1'b0, 1'b0};
  logic        bsy_at_done [2];
  logic        bsyp_at_done [2];
  logic [31:0] held [2];

  task automatic sample();
    for (int k = 0; k < 2; k++) begin
      if (mrd[k]) begin
        mr_n[k]++;
        mr_cyc[k] = cyc;
      end
      if (ov[k] && !ov_p[k])
        chk($sformatf("valid_latency%0d", k), cyc - mr_cyc[k], lat_of(k) + 1);
      if (ov_p[k] && !hs_p[k]) begin
        chk($sformatf("hold_valid%0d", k), {31'd0, ov[k]}, 32'd1);
        chk($sformatf("hold_word%0d", k), {oaddr[k], odata[k]}, held[k]);
      end
      if (ov[k] && ready_i[k]) begin
        hs_a[k][hs_n[k] % 64] = oaddr[k];
        hs_d[k][hs_n[k] % 64] = odata[k];
        hs_c[k][hs_n[k] % 64] = cyc;
        hs_n[k]++;
        hs_p[k] = 1'b1;
      end else begin
        hs_p[k] = 1'b0;
      end
      if (dn[k]) begin
        done_n[k]++;
        done_cyc[k]     = cyc;
        bsy_at_done[k]  = bsy[k];
        bsyp_at_done[k] = bsy_p[k];
      end
      ov_p[k]  = ov[k];
      bsy_p[k] = bsy[k];
      held[k]  = {oaddr[k], odata[k]};
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input int k, input string nm);
    chk({nm, "/mem_addr"},  {16'd0, maddr[k]}, 32'd0);
    chk({nm, "/mem_read"},  {31'd0, mrd[k]},   32'd0);
    chk({nm, "/out_valid"}, {31'd0, ov[k]},    32'd0);
    chk({nm, "/out_data"},  {16'd0, odata[k]}, 32'd0);
    chk({nm, "/out_addr"},  {16'd0, oaddr[k]}, 32'd0);
    chk({nm, "/busy"},      {31'd0, bsy[k]},   32'd0);
    chk({nm, "/done"},      {31'd0, dn[k]},    32'd0);
  endtask

  task automatic run_dump(input int k, input string nm, input logic [15:0] base,
                          input logic [15:0] len, input logic [15:0] pat, input bit intr,
                          input int unsigned exp_n, input logic [15:0] fa, input logic [15:0] la,
                          input logic [15:0] fd, input logic [15:0] ld);
    int unsigned h0, m0, d0, st_cyc, idx;
    logic [15:0] a;
    h0 = hs_n[k]; m0 = mr_n[k]; d0 = done_n[k];
    base_i[k] = base; len_i[k] = len; start_i[k] = 1'b1;
    tick();
    start_i[k] = 1'b0;
    st_cyc = cyc;
    for (int c = 0; c < 400 && done_n[k] == d0; c++) begin
      ready_i[k] = pat[c % 16];
      if (intr && c == 4) begin
        start_i[k] = 1'b1; base_i[k] = 16'h0100; len_i[k] = 16'd7;
      end else begin
        start_i[k] = 1'b0;
      end
      tick();
    end
    for (int c = 0; c < 3; c++) tick();
    chk({nm, "/words"},     hs_n[k] - h0,   exp_n);
    chk({nm, "/reads"},     mr_n[k] - m0,   exp_n);
    chk({nm, "/done_count"}, done_n[k] - d0, 32'd1);
    chk({nm, "/busy_at_done"}, {31'd0, bsy_at_done[k]}, 32'd0);
    chk({nm, "/busy_before_done"}, {31'd0, bsyp_at_done[k]}, {31'd0, exp_n != 0});
    chk({nm, "/busy_after"}, {31'd0, bsy[k]}, 32'd0);
    chk({nm, "/valid_after"}, {31'd0, ov[k]}, 32'd0);
    if (exp_n == 0) begin
      chk({nm, "/done_within_2"}, {31'd0, (done_cyc[k] - st_cyc) <= 2}, 32'd1);
    end else begin
      chk({nm, "/first_addr"}, {16'd0, hs_a[k][h0 % 64]}, {16'd0, fa});
      chk({nm, "/last_addr"},  {16'd0, hs_a[k][(h0 + exp_n - 1) % 64]}, {16'd0, la});
      chk({nm, "/first_data"}, {16'd0, hs_d[k][h0 % 64]}, {16'd0, fd});
      chk({nm, "/last_data"},  {16'd0, hs_d[k][(h0 + exp_n - 1) % 64]}, {16'd0, ld});
      for (int unsigned i = 0; i < exp_n; i++) begin
        idx = (h0 + i) % 64;
        a = base + 16'(i);
        chk($sformatf("%s/addr%0d", nm, i), {16'd0, hs_a[k][idx]}, {16'd0, a});
        chk($sformatf("%s/data%0d", nm, i), {16'd0, hs_d[k][idx]}, {16'd0, ram_word(a)});
        if (pat == 16'hFFFF && i > 0)
          chk($sformatf("%s/gap%0d", nm, i), hs_c[k][idx] - hs_c[k][(h0 + i - 1) % 64],
              lat_of(k) + 2);
      end
    end
  endtask

  typedef struct {
    string       nm;
    int          inst;
    logic [15:0] base;
    logic [15:0] len;
    logic [15:0] pat;
    bit          intr;
    int unsigned exp_n;
    logic [15:0] fa, la, fd, ld;
  } vec_t;

  vec_t vecs [7];
  int unsigned m0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      start_i[k] = 1'b0; base_i[k] = '0; len_i[k] = '0; ready_i[k] = 1'b0;
    end
    vecs[0] = '{"l1_basic",   0, 16'h0010, 16'd4, 16'hFFFF, 1'b0, 4, 16'h0010, 16'h0013, 16'hA000, 16'hA003};
    vecs[1] = '{"l1_stall",   0, 16'h0010, 16'd4, 16'h9639, 1'b0, 4, 16'h0010, 16'h0013, 16'hA000, 16'hA003};
    vecs[2] = '{"l1_wrap",    0, 16'hFFFF, 16'd2, 16'hFFFF, 1'b0, 2, 16'hFFFF, 16'h0000, 16'hA5A5, 16'h5A5A};
    vecs[3] = '{"l1_zero",    0, 16'h1234, 16'd0, 16'hFFFF, 1'b0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[4] = '{"l1_restart", 0, 16'h0040, 16'd4, 16'hFFFF, 1'b1, 4, 16'h0040, 16'h0043, 16'h5A1A, 16'h5A19};
    vecs[5] = '{"l3_basic",   1, 16'h0010, 16'd4, 16'hFFFF, 1'b0, 4, 16'h0010, 16'h0013, 16'hA000, 16'hA003};
    vecs[6] = '{"l3_stall",   1, 16'h0010, 16'd4, 16'h9639, 1'b0, 4, 16'h0010, 16'h0013, 16'hA000, 16'hA003};

    #1 rst = 1'b1;
    #2;
    check_zero(0, "reset0");
    check_zero(1, "reset1");
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    for (int v = 0; v < 7; v++)
      run_dump(vecs[v].inst, vecs[v].nm, vecs[v].base, vecs[v].len, vecs[v].pat,
               vecs[v].intr, vecs[v].exp_n, vecs[v].fa, vecs[v].la, vecs[v].fd, vecs[v].ld);

    // Reset during WAIT of word 2 of 4, then a clean dump from a new base.
    m0 = mr_n[0];
    base_i[0] = 16'h0020; len_i[0] = 16'd4; ready_i[0] = 1'b1; start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    for (int c = 0; c < 100 && mr_n[0] < m0 + 2; c++) tick();
    chk("midreset/busy_before", {31'd0, bsy[0]}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_zero(0, "midreset_async");
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    tick();
    check_zero(0, "midreset_after");
    run_dump(0, "after_reset", 16'h0030, 16'd3, 16'hFFFF, 1'b0, 3,
             16'h0030, 16'h0032, 16'h5A6A, 16'h5A68);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
